// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/I/O responder: I/O map, byte type,
// and the layout of the status byte returned from the control address.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_CTRL = 18'h30004;
  localparam logic [1:0]  IO_SEL  = 2'b11;

  typedef logic [7:0] byte_t;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;

  function automatic byte_t status_byte(input logic tx_full, input logic rx_empty);
    byte_t s;
    s = '0;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_RX_EMPTY] = rx_empty;
    return s;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Show-ahead circular byte FIFO with an explicit occupancy counter.
// Pushes into a full FIFO and pops from an empty one are ignored.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  byte_t                    din_i,
  input  logic                     pop_i,
  output byte_t                    dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  byte_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
    if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: on-chip RAM plus the I/O window at 0x30000 with
// TX/RX byte FIFOs toward the UART, a near-full flag and program termination.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int    RAM_ADDR_WIDTH = 17,
  parameter int    FIFO_DEPTH     = 8,
  parameter int    FULL_MARGIN    = 2,
  parameter string INIT_FILE      = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        prog_end,
  output logic [7:0]  exit_code
);

  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int RAM_WORDS = 1 << RAM_ADDR_WIDTH;

  byte_t ram [RAM_WORDS];

  logic [17:0]               addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      io_sel, hit_data, hit_ctrl;
  logic                      wr_en, rd_en;
  logic                      unused_addr_bits;

  assign addr             = cpu_a[17:0];
  assign ram_addr         = cpu_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^cpu_a[31:18];
  assign io_sel           = (addr[17:16] == IO_SEL);
  assign hit_data         = (addr == IO_BASE);
  assign hit_ctrl         = (addr == IO_CTRL);
  assign wr_en            = rdy_in && cpu_wr;
  assign rd_en            = rdy_in && !cpu_wr;

  always_ff @(posedge clk_in) begin
    if (wr_en && !io_sel) ram[ram_addr] <= cpu_dout;
  end

  // FIFO plumbing
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [CW-1:0] tx_count, tx_count_d, unused_rx_count;
  byte_t         rx_head;

  assign tx_push  = wr_en && hit_data && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_en && hit_data && !rx_empty;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (tx_push),
    .din_i   (cpu_dout),
    .pop_i   (tx_pop),
    .dout_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (rx_push),
    .din_i   (rx_data),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (unused_rx_count)
  );

  // Post-edge TX occupancy feeds the registered near-full flag.
  always_comb begin
    tx_count_d = tx_count;
    if (tx_push && !tx_pop) tx_count_d = tx_count + CW'(1);
    if (tx_pop && !tx_push) tx_count_d = tx_count - CW'(1);
  end

  byte_t io_rdata, rd_byte;

  always_comb begin
    io_rdata = '0;
    if (hit_data)      io_rdata = rx_empty ? 8'h00 : rx_head;
    else if (hit_ctrl) io_rdata = status_byte(tx_full, rx_empty);
    rd_byte = io_sel ? io_rdata : ram[ram_addr];
  end

  byte_t cpu_din_q, cpu_din_d, exit_code_q, exit_code_d;
  logic  io_full_q, io_full_d, tx_ovf_q, tx_ovf_d, prog_end_q, prog_end_d;

  always_comb begin
    cpu_din_d   = cpu_din_q;
    tx_ovf_d    = tx_ovf_q;
    prog_end_d  = prog_end_q;
    exit_code_d = exit_code_q;
    io_full_d   = (tx_count_d >= CW'(FIFO_DEPTH - FULL_MARGIN));
    if (rd_en) cpu_din_d = rd_byte;
    if (wr_en && hit_data && tx_full) tx_ovf_d = 1'b1;
    if (wr_en && hit_ctrl && !prog_end_q) begin
      prog_end_d  = 1'b1;
      exit_code_d = cpu_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_din_q   <= '0;
      io_full_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
      prog_end_q  <= 1'b0;
      exit_code_q <= '0;
    end else begin
      cpu_din_q   <= cpu_din_d;
      io_full_q   <= io_full_d;
      tx_ovf_q    <= tx_ovf_d;
      prog_end_q  <= prog_end_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign cpu_din        = cpu_din_q;
  assign io_buffer_full = io_full_q;
  assign tx_overflow    = tx_ovf_q;
  assign prog_end       = prog_end_q;
  assign exit_code      = exit_code_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM round trip, TX/RX FIFOs,
// overflow, termination, stall and mid-stream reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, cpu_wr, tx_ready, rx_valid;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, rx_data;
  logic [7:0]  cpu_din, tx_data, exit_code;
  logic        io_buffer_full, tx_valid, rx_ready, tx_overflow, prog_end;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_overflow    (tx_overflow),
    .prog_end       (prog_end),
    .exit_code      (exit_code)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: called at #1 after a rising edge, return at #1 after the next
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_wr = 1'b1; cpu_dout = d;
    tick();
    cpu_a = '0; cpu_wr = 1'b0; cpu_dout = '0;
  endtask

  task automatic cpu_read(input logic [31:0] a);
    cpu_a = a; cpu_wr = 1'b0;
    tick();
    cpu_a = '0;
  endtask

  task automatic uart_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic drain_tx(input string tag);
    tx_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (tx_valid) check(tag, tx_data, exp_q.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_empty"}, tx_valid, 1'b0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; cpu_wr = 1'b0; cpu_a = '0; cpu_dout = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_io_full", io_buffer_full, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_tx_ovf", tx_overflow, 1'b0);
    check("rst_prog_end", prog_end, 1'b0);
    check("rst_exit_code", exit_code, 8'h00);
    rst_in = 1'b0;

    // RAM round trip, back-to-back write then read
    cpu_write(32'h0001_0010 & 32'h0000_0010, 8'hA5);
    cpu_read(32'h10);
    check("ram_10", cpu_din, 8'hA5);
    cpu_write(32'h1FFFF, 8'h3C);
    cpu_read(32'h1FFFF);
    check("ram_1ffff", cpu_din, 8'h3C);
    cpu_read(32'h10);
    check("ram_10_again", cpu_din, 8'hA5);

    // TX fill with UART stalled
    for (int i = 0; i < 9; i++) begin
      cpu_write(32'h30000, 8'h41 + 8'(i));
      if (i < 8) exp_q.push_back(8'h41 + 8'(i));
      if (i == 4) check("io_full_after5", io_buffer_full, 1'b0);
      if (i == 5) check("io_full_after6", io_buffer_full, 1'b1);
      if (i == 7) check("tx_ovf_after8", tx_overflow, 1'b0);
    end
    check("tx_ovf_after9", tx_overflow, 1'b1);
    check("tx_valid_full", tx_valid, 1'b1);
    cpu_read(32'h30004);
    check("status_txfull", cpu_din, 8'h03);
    drain_tx("tx_drain");
    check("io_full_drained", io_buffer_full, 1'b0);
    check("tx_ovf_sticky", tx_overflow, 1'b1);

    // RX path
    uart_push(8'h31);
    uart_push(8'h32);
    cpu_read(32'h30000);
    check("rx_rd0", cpu_din, 8'h31);
    cpu_read(32'h30000);
    check("rx_rd1", cpu_din, 8'h32);
    cpu_read(32'h30000);
    check("rx_rd_empty", cpu_din, 8'h00);
    cpu_read(32'h30004);
    check("status_rxempty", cpu_din, 8'h01);
    cpu_read(32'h10);
    cpu_read(32'h30008);
    check("io_other_rd", cpu_din, 8'h00);

    // Simultaneous push into full TX and UART pop
    do_reset();
    for (int i = 0; i < 8; i++) cpu_write(32'h30000, 8'h50 + 8'(i));
    check("sim_io_full", io_buffer_full, 1'b1);
    check("sim_no_ovf", tx_overflow, 1'b0);
    tx_ready = 1'b1;
    cpu_write(32'h30000, 8'h58);
    tx_ready = 1'b0;
    check("sim_ovf", tx_overflow, 1'b1);
    check("sim_io_full7", io_buffer_full, 1'b1);
    cpu_read(32'h30004);
    check("sim_status", cpu_din, 8'h01);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h50 + 8'(i));
    drain_tx("sim_drain");

    // Termination
    cpu_write(32'h30004, 8'h07);
    check("prog_end_set", prog_end, 1'b1);
    check("exit_code_first", exit_code, 8'h07);
    cpu_write(32'h30004, 8'h09);
    check("exit_code_kept", exit_code, 8'h07);
    cpu_read(32'h10);
    check("ram_after_end", cpu_din, 8'hA5);

    // Stall
    cpu_write(32'h20, 8'h5A);
    cpu_read(32'h10);
    check("stall_pre", cpu_din, 8'hA5);
    rdy_in = 1'b0;
    cpu_write(32'h20, 8'hFF);
    check("stall_din_hold_w", cpu_din, 8'hA5);
    cpu_read(32'h20);
    check("stall_din_hold_r", cpu_din, 8'hA5);
    cpu_write(32'h30000, 8'h77);
    check("stall_no_push", tx_valid, 1'b0);
    rdy_in = 1'b1;
    cpu_read(32'h20);
    check("stall_ram_kept", cpu_din, 8'h5A);

    // Reset mid-stream
    cpu_write(32'h30000, 8'h61);
    cpu_write(32'h30000, 8'h62);
    uart_push(8'h71);
    cpu_read(32'h10);
    check("pre_rst_din", cpu_din, 8'hA5);
    rst_in = 1'b1;
    tick();
    check("mrst_cpu_din", cpu_din, 8'h00);
    check("mrst_io_full", io_buffer_full, 1'b0);
    check("mrst_tx_valid", tx_valid, 1'b0);
    check("mrst_rx_ready", rx_ready, 1'b1);
    check("mrst_tx_ovf", tx_overflow, 1'b0);
    check("mrst_prog_end", prog_end, 1'b0);
    check("mrst_exit_code", exit_code, 8'h00);
    rst_in = 1'b0;
    cpu_read(32'h30000);
    check("mrst_rx_flushed", cpu_din, 8'h00);
    cpu_read(32'h30004);
    check("mrst_status", cpu_din, 8'h01);
    cpu_read(32'h1FFFF);
    check("mrst_ram_kept", cpu_din, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
